run_decoder: RTL and testbench
==============================

# run_decoder

Inverse of the run-length stage in the JPEG-style pipeline. Consumes one block's token stream (DC value, then AC run/size/symbol tokens, including ZRL and EOB) and expands it back into 64 signed quantized coefficients in scan order. Sits between the entropy/Huffman decode stage and dequantization. Uses the same ena/rdy handshake on both sides as the rest of the pipeline.

## Interface
- No parameters; block length is fixed at 64 coefficients.
- clk     in   1   clock; all state on rising edge
- rst     in   1   reset, asynchronous, active-low
- ena_in  in   1   input token valid
- rdy_out out  1   decoder can accept a token this cycle
- dc      in   1   token is a DC token (uses in_dc)
- in_dc   in   11  signed DC value
- run     in   4   count of preceding zero coefficients (AC)
- size    in   4   magnitude category (AC); 0 means ZRL/EOB
- in      in   10  AC symbol, two's-complement form described below
- ena_out out  1   out/idx valid
- rdy_in  in   1   downstream accepts the coefficient this cycle
- out     out  11  signed coefficient
- idx     out  6   scan index of out (0..63)
- done    out  1   idle between blocks
- err     out  1   sticky protocol error

## Operation
- Token transfer happens on a rising edge where ena_in && rdy_out. Coefficient transfer happens on a rising edge where ena_out && rdy_in.
- States:
  - S_DC: expect a DC token.
  - S_AC: expect an AC token.
  - S_ZERO: emitting run zeros; a down-counter tracks how many remain.
  - S_VAL: emitting the held value.
  - S_FILL: EOB zero fill up to index 63.
- DC token in S_DC:
  - Emits out=in_dc at idx 0.
  - Goes to S_AC.
- AC token (run r, size s>0):
  - Emits r zeros, then the value v.
  - v = sign-extend(in) + in[9]. Examples: 002→2, 3fd→-2, 3f5→-10.
  - Returns to S_AC, or to S_DC if idx 63 was just emitted.
- ZRL (run 15, size 0): emits 16 zeros.
- EOB (run 0, size 0): S_FILL emits zeros through idx 63, then goes to S_DC.
- EOB is never sent when coefficient 63 is nonzero. The block completes automatically after idx 63 is transferred.
- Other run≠0 with size 0: treated as ZRL, and err is set.
- Overrun: if an AC token would place coefficients past idx 63:
  - Zeros are emitted through idx 63.
  - The value is dropped.
  - err is set.
  - Next state is S_DC.
- Wrong token class:
  - A dc=1 token in S_AC, or a dc=0 token in S_DC, is consumed and ignored, and err is set.
- err clears only on reset.
- idx increments by 1 per coefficient transfer and wraps 63→0 at block end.

## Timing
- Reset (rst low, async) values:
  - ena_out=0, out=0, idx=0, err=0, done=1.
  - State S_DC.
  - rdy_out=0 while rst is low.
- rdy_out is combinational: high iff state is S_DC or S_AC and (!ena_out || rdy_in).
- Latency: a token accepted at edge N puts its first coefficient on out with ena_out=1 after edge N; it is visible in cycle N+1.
- Throughput: one coefficient per cycle while rdy_in=1. Back-to-back run-0 tokens are accepted every cycle.
- A token with run r occupies r+1 output cycles. rdy_out stays low during the zeros.
- With rdy_in=0, out, idx and ena_out hold stable. No coefficient is dropped or duplicated.
- done:
  - Falls the cycle after a DC token is accepted.
  - Rises the cycle after the idx-63 transfer.
- Reset mid-block abandons the block immediately. The next token is expected to be a DC token.

## Configuration
- RUN_DECODER_DC_PRED_EN:
  - Defined: in_dc is a difference. out at idx 0 = pred + in_dc (11-bit wrap), and pred is updated to that value. pred resets to 0 on rst.
  - Undefined: in_dc passes through unchanged, and no predictor register exists.

## Test plan
- Full block, rdy_in=1:
  - Stimulus: DC 0, then tokens (0,2,002) (0,2,3fd) (0,4,3f5) (0,4,3f4) (0,1,3fe) (0,1,001)×2 (0,3,006) (0,2,003) (1,1,001) (0,2,003) (0,1,3fe) (4,1,3fe) (0,1,3fe) (2,1,001) (0,1,001) ZRL (9,1,001) EOB.
  - Required: out = 0,2,-2,-10,-11,-1,1,1,6,3,0,1,3,-1,0,0,0,0,-1,-1,0,0,1,1, then zeros except 1 at idx 49.
  - Required: 64 transfers, done=1 afterwards, err=0.
- Same stream with rdy_in high one cycle in three: identical 64-value sequence, and out/idx stable while stalled.
- No-EOB block:
  - Stimulus: DC 5, ZRL×3, (14,1,001), then DC 7.
  - Required: idx 63 carries 1, done rises, and 7 is emitted at idx 0 of the next block with err=0.
- Overrun:
  - Stimulus: DC 0, ZRL×3, (15,1,001).
  - Required: 15 zeros at idx 49..63, value dropped, err=1, state back to S_DC.
- Reset mid-block:
  - Stimulus: assert rst after 10 transfers.
  - Required: ena_out=0 and done=1 immediately; after release, the sample block decodes correctly.
- DC prediction:
  - Stimulus: two EOB-only blocks with in_dc 5 then -3.
  - Required: idx 0 outputs are 5, 2 with the macro defined; 5, -3 without it.

Source files
------------

// File: rtl/run_decoder.sv
// run_decoder: expands one block's DC / AC run-length token stream into 64 signed
// scan-order coefficients. Define RUN_DECODER_DC_PRED_EN to treat in_dc as a DC difference.
module run_decoder (
    input  logic               clk,
    input  logic               rst,
    input  logic               ena_in,
    output logic               rdy_out,
    input  logic               dc,
    input  logic signed [10:0] in_dc,
    input  logic [3:0]         run,
    input  logic [3:0]         size,
    input  logic [9:0]         in,
    output logic               ena_out,
    input  logic               rdy_in,
    output logic signed [10:0] out,
    output logic [5:0]         idx,
    output logic               done,
    output logic               err
);

    typedef enum logic [2:0] {
        S_DC,
        S_AC,
        S_ZERO,
        S_VAL,
        S_FILL
    } state_t;

    state_t             state, state_nx;
    logic [3:0]         zcnt, zcnt_nx;
    logic signed [10:0] hold, hold_nx;
    logic               has_val, has_val_nx;
    logic               last, last_nx;
    logic               ena_out_nx;
    logic signed [10:0] out_nx;
    logic [5:0]         idx_nx;
    logic               done_nx;
    logic               err_nx;

    logic               xfer;
    logic               adv;
    logic               tok;
    logic [6:0]         pos;
    logic               eob;
    logic               zrl_like;
    logic [3:0]         eff_run;
    logic [3:0]         rem;
    logic [6:0]         end_pos;
    logic               overrun;
    logic               tok_last;
    logic               tok_has_val;
    logic signed [10:0] ac_val;
    logic signed [10:0] dc_val;
    state_t             after_zero;
    state_t             tok_after_zero;

    assign xfer    = ena_out && rdy_in;
    assign adv     = !ena_out || rdy_in;
    assign rdy_out = rst && (state == S_DC || state == S_AC) && adv;
    assign tok     = ena_in && rdy_out;

    // Index the first coefficient of an accepted token will occupy: the slot after
    // the one currently presented, since acceptance implies that one transfers now.
    assign pos      = {1'b0, idx} + {6'd0, ena_out};
    assign eob      = (size == 4'd0) && (run == 4'd0);
    assign zrl_like = (size == 4'd0) && (run != 4'd0);
    assign eff_run  = zrl_like ? 4'd15 : run;
    assign end_pos  = pos + {3'd0, eff_run};
    assign overrun  = end_pos > 7'd63;
    assign tok_last = end_pos == 7'd63;

    assign tok_has_val = !zrl_like;
    assign rem         = zrl_like ? 4'd15 : run - 4'd1;
    assign ac_val      = {in[9], in} + {10'd0, in[9]};

    assign after_zero     = has_val ? S_VAL : (last ? S_DC : S_AC);
    assign tok_after_zero = tok_has_val ? S_VAL : (tok_last ? S_DC : S_AC);

`ifdef RUN_DECODER_DC_PRED_EN
    logic signed [10:0] pred;

    assign dc_val = pred + in_dc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pred <= '0;
        end else if (tok && state == S_DC && dc) begin
            pred <= dc_val;
        end
    end
`else
    assign dc_val = in_dc;
`endif

    always_comb begin
        // NOTE: every signal written here gets its hold value first, so no path leaves it unassigned and no latch is inferred.
        state_nx   = state;
        zcnt_nx    = zcnt;
        hold_nx    = hold;
        has_val_nx = has_val;
        last_nx    = last;
        out_nx     = out;
        ena_out_nx = ena_out && !rdy_in;
        idx_nx     = xfer ? idx + 6'd1 : idx;
        done_nx    = done || (xfer && idx == 6'd63);
        err_nx     = err;

        unique case (state)
            S_DC: begin
                if (tok) begin
                    if (dc) begin
                        out_nx     = dc_val;
                        ena_out_nx = 1'b1;
                        done_nx    = 1'b0;
                        state_nx   = S_AC;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            end
            S_AC: begin
                if (tok) begin
                    if (dc) begin
                        err_nx = 1'b1;
                    end else if (eob || overrun) begin
                        // Both cases zero-fill the rest of the block; an overrun drops its value.
                        out_nx     = '0;
                        ena_out_nx = 1'b1;
                        err_nx     = err || overrun;
                        state_nx   = (pos == 7'd63) ? S_DC : S_FILL;
                    end else begin
                        err_nx     = err || (zrl_like && run != 4'd15);
                        hold_nx    = ac_val;
                        has_val_nx = tok_has_val;
                        last_nx    = tok_last;
                        ena_out_nx = 1'b1;
                        if (tok_has_val && run == 4'd0) begin
                            out_nx   = ac_val;
                            state_nx = tok_last ? S_DC : S_AC;
                        end else begin
                            out_nx   = '0;
                            zcnt_nx  = rem;
                            state_nx = (rem == 4'd0) ? tok_after_zero : S_ZERO;
                        end
                    end
                end
            end
            S_ZERO: begin
                if (adv) begin
                    out_nx     = '0;
                    ena_out_nx = 1'b1;
                    zcnt_nx    = zcnt - 4'd1;
                    if (zcnt == 4'd1) begin
                        state_nx = after_zero;
                    end
                end
            end
            S_VAL: begin
                if (adv) begin
                    out_nx     = hold;
                    ena_out_nx = 1'b1;
                    state_nx   = last ? S_DC : S_AC;
                end
            end
            S_FILL: begin
                if (adv) begin
                    out_nx     = '0;
                    ena_out_nx = 1'b1;
                    if (pos == 7'd63) begin
                        state_nx = S_DC;
                    end
                end
            end
            default: begin
                state_nx = S_DC;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_DC;
            zcnt    <= '0;
            hold    <= '0;
            has_val <= 1'b0;
            last    <= 1'b0;
            ena_out <= 1'b0;
            out     <= '0;
            idx     <= '0;
            done    <= 1'b1;
            err     <= 1'b0;
        end else begin
            // NOTE: state registers update with nonblocking assignments so every flop samples pre-edge values.
            state   <= state_nx;
            zcnt    <= zcnt_nx;
            hold    <= hold_nx;
            has_val <= has_val_nx;
            last    <= last_nx;
            ena_out <= ena_out_nx;
            out     <= out_nx;
            idx     <= idx_nx;
            done    <= done_nx;
            err     <= err_nx;
        end
    end

endmodule

// File: tb/tb_run_decoder.sv
// Self-checking bench for run_decoder: directed blocks plus randomized token streams checked
// against a block-level expansion model; honours RUN_DECODER_DC_PRED_EN when defined.
module tb_run_decoder;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               ena_in = 1'b0;
    logic               dc = 1'b0;
    logic signed [10:0] in_dc = '0;
    logic [3:0]         run = '0;
    logic [3:0]         size = '0;
    logic [9:0]         in = '0;
    logic               rdy_in = 1'b0;
    logic               rdy_out;
    logic               ena_out;
    logic signed [10:0] out;
    logic [5:0]         idx;
    logic               done;
    logic               err;

    always #5 clk = ~clk;

    run_decoder dut (
        .clk    (clk),
        .rst    (rst),
        .ena_in (ena_in),
        .rdy_out(rdy_out),
        .dc     (dc),
        .in_dc  (in_dc),
        .run    (run),
        .size   (size),
        .in     (in),
        .ena_out(ena_out),
        .rdy_in (rdy_in),
        .out    (out),
        .idx    (idx),
        .done   (done),
        .err    (err)
    );

`ifdef RUN_DECODER_DC_PRED_EN
    localparam bit PRED_EN = 1'b1;
`else
    localparam bit PRED_EN = 1'b0;
`endif

    typedef struct { bit is_dc; int dcv; int r; int s; int sym; } tok_t;
    typedef struct { int i; int v; } coef_t;

    tok_t  tok_q[$];
    coef_t got_q[$];
    coef_t exp_q[$];
    int    n_checks = 0;
    int    n_fail = 0;
    logic  done_mid;

    // Reference model state: next scan position (-1 = awaiting DC), predictor, sticky error.
    int    m_pos = -1;
    int    m_pred = 0;
    bit    m_err = 1'b0;

    function automatic void add_dc(int v);
        tok_t t;
        t.is_dc = 1'b1; t.dcv = v; t.r = 0; t.s = 0; t.sym = 0;
        tok_q.push_back(t);
    endfunction

    function automatic void add_ac(int r, int s, int sym);
        tok_t t;
        t.is_dc = 1'b0; t.dcv = 0; t.r = r; t.s = s; t.sym = sym;
        tok_q.push_back(t);
    endfunction

    function automatic int wrap11(int v);
        int w;
        w = ((v % 2048) + 2048) % 2048;
        return (w >= 1024) ? w - 2048 : w;
    endfunction

    function automatic int sym_value(int sym);
        return (sym >= 512) ? sym - 1023 : sym;
    endfunction

    function automatic void mpush(int v);
        coef_t c;
        c.i = m_pos; c.v = v;
        exp_q.push_back(c);
        m_pos++;
    endfunction

    function automatic void model_tokens();
        foreach (tok_q[k]) begin
            int zeros;
            int nv;
            zeros = (tok_q[k].s == 0) ? 16 : tok_q[k].r;
            nv    = (tok_q[k].s != 0) ? 1 : 0;
            if (m_pos < 0) begin
                if (!tok_q[k].is_dc) begin
                    m_err = 1'b1;
                end else begin
                    m_pred = PRED_EN ? wrap11(m_pred + tok_q[k].dcv) : tok_q[k].dcv;
                    m_pos = 0;
                    mpush(m_pred);
                end
            end else if (tok_q[k].is_dc) begin
                m_err = 1'b1;
            end else if (tok_q[k].s == 0 && tok_q[k].r == 0) begin
                while (m_pos < 64) mpush(0);
            end else begin
                if (tok_q[k].s == 0 && tok_q[k].r != 15) m_err = 1'b1;
                if (m_pos + zeros + nv > 64) begin
                    m_err = 1'b1;
                    while (m_pos < 64) mpush(0);
                end else begin
                    repeat (zeros) mpush(0);
                    if (nv == 1) mpush(sym_value(tok_q[k].sym));
                end
            end
            if (m_pos == 64) m_pos = -1;
        end
    endfunction

    task automatic load_sample();
        add_dc(0);
        add_ac(0, 2, 'h002); add_ac(0, 2, 'h3fd); add_ac(0, 4, 'h3f5); add_ac(0, 4, 'h3f4);
        add_ac(0, 1, 'h3fe); add_ac(0, 1, 'h001); add_ac(0, 1, 'h001); add_ac(0, 3, 'h006);
        add_ac(0, 2, 'h003); add_ac(1, 1, 'h001); add_ac(0, 2, 'h003); add_ac(0, 1, 'h3fe);
        add_ac(4, 1, 'h3fe); add_ac(0, 1, 'h3fe); add_ac(2, 1, 'h001); add_ac(0, 1, 'h001);
        add_ac(15, 0, 0);    add_ac(9, 1, 'h001); add_ac(0, 0, 0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        ena_in = 1'b0;
        rdy_in = 1'b0;
        rst    = 1'b0;
        repeat (2) @(negedge clk);
        rst    = 1'b1;
        m_pos  = -1;
        m_pred = 0;
        m_err  = 1'b0;
    endtask

    // Sends tok_q and records transfers until n_stop coefficients are seen.
    // mode 0: rdy_in always high, 1: high one cycle in three, 2: random rdy_in and ena_in gaps.
    task automatic drive(input int mode, input int n_stop, output int cycles);
        int            ti;
        bit            stalled;
        logic [10:0]   s_out;
        logic [5:0]    s_idx;
        coef_t         c;
        ti      = 0;
        cycles  = 0;
        stalled = 1'b0;
        s_out   = '0;
        s_idx   = '0;
        got_q.delete();
        while (got_q.size() < n_stop) begin
            // NOTE: inputs change on the falling edge and outputs are sampled just after it, clear of the active edge.
            @(negedge clk);
            case (mode)
                0:       rdy_in = 1'b1;
                1:       rdy_in = (cycles % 3 == 0);
                default: rdy_in = 1'($urandom_range(0, 1));
            endcase
            if (ti < tok_q.size() && (mode != 2 || $urandom_range(0, 3) != 0)) begin
                ena_in = 1'b1;
                dc     = tok_q[ti].is_dc;
                in_dc  = 11'(tok_q[ti].dcv);
                run    = 4'(tok_q[ti].r);
                size   = 4'(tok_q[ti].s);
                in     = 10'(tok_q[ti].sym);
            end else begin
                ena_in = 1'b0;
            end
            #1;
            if (stalled) begin
                n_checks++;
                if (ena_out !== 1'b1 || out !== s_out || idx !== s_idx) begin
                    n_fail++;
                    $display("FAIL stall_hold: got ena_out=%b out=%0d idx=%0d want ena_out=1 out=%0d idx=%0d",
                             ena_out, out, idx, $signed(s_out), s_idx);
                end
            end
            stalled = ena_out && !rdy_in;
            s_out   = out;
            s_idx   = idx;
            if (ena_out && rdy_in) begin
                c.i = int'(idx);
                c.v = int'(out);
                got_q.push_back(c);
                if (got_q.size() == 5) done_mid = done;
            end
            if (ena_in && rdy_out) ti++;
            cycles++;
            if (cycles > 4000) begin
                n_checks++;
                n_fail++;
                $display("FAIL drive_timeout: got %0d coefficients want %0d", got_q.size(), n_stop);
                break;
            end
        end
        @(posedge clk);
        #1;
        ena_in = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (ena_out !== 1'b0 || out !== 11'sd0 || idx !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ena_out=%b out=%0d idx=%0d want 0 0 0", ena_out, out, idx);
        end
        n_checks++;
        if (done !== 1'b1 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got done=%b err=%b want done=1 err=0", done, err);
        end
        n_checks++;
        if (rdy_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_rdy_out: got %b want 0", rdy_out);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if (rdy_out !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_rdy_out: got %b want 1", rdy_out);
        end
    endtask

    task automatic test_sample_block();
        int head[24] = '{0, 2, -2, -10, -11, -1, 1, 1, 6, 3, 0, 1, 3, -1, 0, 0, 0, 0, -1, -1, 0, 0, 1, 1};
        int want;
        int cyc;
        tok_q.delete(); exp_q.delete();
        load_sample();
        model_tokens();
        done_mid = 1'bx;
        drive(0, 64, cyc);
        n_checks++;
        if (got_q.size() != 64) begin
            n_fail++;
            $display("FAIL sample_count: got %0d want 64", got_q.size());
        end
        for (int k = 0; k < 64 && k < got_q.size(); k++) begin
            want = (k < 24) ? head[k] : ((k == 49) ? 1 : 0);
            n_checks++;
            if (got_q[k].i != k || got_q[k].v != want) begin
                n_fail++;
                $display("FAIL sample_coef[%0d]: got idx %0d val %0d want idx %0d val %0d",
                         k, got_q[k].i, got_q[k].v, k, want);
            end
        end
        n_checks++;
        if (done_mid !== 1'b0) begin
            n_fail++;
            $display("FAIL sample_done_mid: got %b want 0", done_mid);
        end
        n_checks++;
        if (done !== 1'b1 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL sample_end_flags: got done=%b err=%b want done=1 err=0", done, err);
        end
    endtask

    task automatic test_stalled();
        int cyc;
        tok_q.delete(); exp_q.delete();
        load_sample();
        model_tokens();
        drive(1, exp_q.size(), cyc);
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL stalled_count: got %0d want %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[k]) begin
            if (k < got_q.size()) begin
                n_checks++;
                if (got_q[k].i != exp_q[k].i || got_q[k].v != exp_q[k].v) begin
                    n_fail++;
                    $display("FAIL stalled_coef[%0d]: got idx %0d val %0d want idx %0d val %0d",
                             k, got_q[k].i, got_q[k].v, exp_q[k].i, exp_q[k].v);
                end
            end
        end
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL stalled_err: got %b want 0", err);
        end
    endtask

    task automatic test_no_eob();
        int cyc;
        tok_q.delete(); exp_q.delete();
        add_dc(5);
        add_ac(15, 0, 0); add_ac(15, 0, 0); add_ac(15, 0, 0);
        add_ac(14, 1, 'h001);
        model_tokens();
        drive(0, 64, cyc);
        n_checks++;
        if (got_q.size() != 64 || got_q[got_q.size() - 1].i != 63 || got_q[got_q.size() - 1].v != 1) begin
            n_fail++;
            $display("FAIL no_eob_last: got count %0d want 64 with idx 63 = 1", got_q.size());
        end
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL no_eob_done: got %b want 1", done);
        end
        tok_q.delete(); exp_q.delete();
        add_dc(7);
        add_ac(0, 0, 0);
        model_tokens();
        drive(0, 64, cyc);
        n_checks++;
        if (got_q.size() != 64 || got_q[0].i != 0 || got_q[0].v != exp_q[0].v) begin
            n_fail++;
            $display("FAIL no_eob_next_dc: got count %0d want 64 with idx 0 = %0d", got_q.size(), exp_q[0].v);
        end
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL no_eob_err: got %b want 0", err);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        tok_q.delete(); exp_q.delete();
        add_dc(int'($urandom_range(0, 2047)) - 1024);
        repeat (63) add_ac(0, int'($urandom_range(1, 15)), int'($urandom_range(0, 1023)));
        model_tokens();
        drive(0, exp_q.size(), cyc);
        n_checks++;
        if (cyc != 65) begin
            n_fail++;
            $display("FAIL back_to_back_cycles: got %0d want 65", cyc);
        end
        foreach (exp_q[k]) begin
            if (k < got_q.size()) begin
                n_checks++;
                if (got_q[k].i != exp_q[k].i || got_q[k].v != exp_q[k].v) begin
                    n_fail++;
                    $display("FAIL back_to_back_coef[%0d]: got idx %0d val %0d want idx %0d val %0d",
                             k, got_q[k].i, got_q[k].v, exp_q[k].i, exp_q[k].v);
                end
            end
        end
    endtask

    task automatic test_overrun();
        int cyc;
        tok_q.delete(); exp_q.delete();
        add_dc(0);
        add_ac(15, 0, 0); add_ac(15, 0, 0); add_ac(15, 0, 0);
        add_ac(15, 1, 'h001);
        model_tokens();
        drive(0, exp_q.size(), cyc);
        n_checks++;
        if (got_q.size() != 64) begin
            n_fail++;
            $display("FAIL overrun_count: got %0d want 64", got_q.size());
        end
        for (int k = 49; k < 64 && k < got_q.size(); k++) begin
            n_checks++;
            if (got_q[k].i != k || got_q[k].v != 0) begin
                n_fail++;
                $display("FAIL overrun_fill[%0d]: got idx %0d val %0d want idx %0d val 0",
                         k, got_q[k].i, got_q[k].v, k);
            end
        end
        n_checks++;
        if (err !== 1'b1 || m_err !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_err: got %b want 1", err);
        end
        tok_q.delete(); exp_q.delete();
        add_dc(9);
        add_ac(0, 0, 0);
        model_tokens();
        drive(0, 64, cyc);
        n_checks++;
        if (got_q.size() != 64 || got_q[0].i != 0 || got_q[0].v != exp_q[0].v) begin
            n_fail++;
            $display("FAIL overrun_next_dc: got count %0d want 64 with idx 0 = %0d", got_q.size(), exp_q[0].v);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        tok_q.delete(); exp_q.delete();
        load_sample();
        drive(0, 10, cyc);
        rst = 1'b0;
        #1;
        n_checks++;
        if (ena_out !== 1'b0 || done !== 1'b1 || rdy_out !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got ena_out=%b done=%b rdy_out=%b err=%b want 0 1 0 0",
                     ena_out, done, rdy_out, err);
        end
        m_pos  = -1;
        m_pred = 0;
        m_err  = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        model_tokens();
        drive(0, exp_q.size(), cyc);
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL reset_mid_count: got %0d want %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[k]) begin
            if (k < got_q.size()) begin
                n_checks++;
                if (got_q[k].i != exp_q[k].i || got_q[k].v != exp_q[k].v) begin
                    n_fail++;
                    $display("FAIL reset_mid_coef[%0d]: got idx %0d val %0d want idx %0d val %0d",
                             k, got_q[k].i, got_q[k].v, exp_q[k].i, exp_q[k].v);
                end
            end
        end
    endtask

    task automatic test_dc_pred();
        int cyc;
        int want2;
        apply_reset();
        tok_q.delete(); exp_q.delete();
        add_dc(5);  add_ac(0, 0, 0);
        add_dc(-3); add_ac(0, 0, 0);
        model_tokens();
        want2 = PRED_EN ? 2 : -3;
        drive(0, 128, cyc);
        n_checks++;
        if (got_q.size() != 128 || got_q[0].i != 0 || got_q[0].v != 5) begin
            n_fail++;
            $display("FAIL dc_pred_first: got count %0d want 128 with idx 0 = 5", got_q.size());
        end
        n_checks++;
        if (got_q.size() != 128 || got_q[64].i != 0 || got_q[64].v != want2) begin
            n_fail++;
            $display("FAIL dc_pred_second: got count %0d want 128 with idx 0 = %0d", got_q.size(), want2);
        end
    endtask

    task automatic test_random();
        int cyc;
        apply_reset();
        tok_q.delete(); exp_q.delete();
        repeat (4) begin
            int p;
            int k;
            int r;
            if ($urandom_range(0, 7) == 0) add_ac(1, 1, 5);
            add_dc(int'($urandom_range(0, 2047)) - 1024);
            p = 1;
            while (p < 64) begin
                k = int'($urandom_range(0, 23));
                if (k == 0) begin
                    add_ac(0, 0, 0);
                    p = 64;
                end else if (k == 1) begin
                    add_ac(15, 0, 0);
                    p += 16;
                end else if (k == 2) begin
                    add_dc(3);
                end else if (k == 3) begin
                    add_ac(3, 0, 0);
                    p += 16;
                end else begin
                    r = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 2));
                    add_ac(r, int'($urandom_range(1, 15)), int'($urandom_range(0, 1023)));
                    p += r + 1;
                end
            end
        end
        model_tokens();
        drive(2, exp_q.size(), cyc);
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL random_count: got %0d want %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[k]) begin
            if (k < got_q.size()) begin
                n_checks++;
                if (got_q[k].i != exp_q[k].i || got_q[k].v != exp_q[k].v) begin
                    n_fail++;
                    $display("FAIL random_coef[%0d]: got idx %0d val %0d want idx %0d val %0d",
                             k, got_q[k].i, got_q[k].v, exp_q[k].i, exp_q[k].v);
                end
            end
        end
        n_checks++;
        if (err !== m_err || done !== 1'b1) begin
            n_fail++;
            $display("FAIL random_flags: got err=%b done=%b want err=%b done=1", err, done, m_err);
        end
    endtask

    initial begin
        test_reset();
        test_sample_block();
        test_stalled();
        test_no_eob();
        test_back_to_back();
        test_overrun();
        test_reset_mid();
        test_dc_pred();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
